pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_reg_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: control-bundle layout and default kill mask.
package pipe_pkg;

    localparam int CTRL_W_DEF = 12;

    // Control-bundle field offsets.
    localparam int WREG_B   = 0;
    localparam int M2REG_B  = 1;
    localparam int WMEM_B   = 2;
    localparam int ALUC_LSB = 3;   // 4-bit ALU control, bits 6:3
    localparam int SELA_LSB = 7;   // 2-bit operand-A select, bits 8:7
    localparam int SELB_LSB = 9;   // 2-bit operand-B select, bits 10:9
    localparam int STHZ_B   = 11;

    // Only the architecturally visible side effects are killed on a bubble or flush.
    localparam logic [CTRL_W_DEF-1:0] KILL_MASK_DEF =
        CTRL_W_DEF'((1 << WREG_B) | (1 << WMEM_B) | (1 << STHZ_B));

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with stall, flush and bubble handling plus event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W           = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] KILL_MASK        = CTRL_W'(KILL_MASK_DEF),
    parameter int                REG_AW           = 5,
    parameter int                DATA_W           = 32,
    parameter int                NUM_DATA         = 3,
    parameter int                CLR_DATA_ON_KILL = 0,
    parameter int                CNT_W            = 16
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       bubble,
    input  logic                       in_valid,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [REG_AW-1:0]          in_wn,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [REG_AW-1:0]          out_wn,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam logic CLR_DATA = (CLR_DATA_ON_KILL != 0);

    logic                       valid_reg,  valid_next;
    logic [CTRL_W-1:0]          ctrl_reg,   ctrl_next;
    logic [REG_AW-1:0]          wn_reg,     wn_next;
    logic [NUM_DATA*DATA_W-1:0] data_reg,   data_next;

    logic hold_en;
    logic kill_en;
    logic load_en;

    // flush > stall > bubble > load
    assign hold_en = !flush && stall;
    assign kill_en = flush || (!stall && bubble);
    assign load_en = !flush && !stall && !bubble;

    always_comb begin
        valid_next = valid_reg;
        ctrl_next  = ctrl_reg;
        wn_next    = wn_reg;
        if (flush) begin
            valid_next = 1'b0;
            ctrl_next  = ctrl_reg & ~KILL_MASK;
        end else if (stall) begin
            valid_next = valid_reg;
        end else if (bubble) begin
            valid_next = 1'b0;
            ctrl_next  = in_ctrl & ~KILL_MASK;
        end else begin
            valid_next = in_valid;
            ctrl_next  = in_valid ? in_ctrl : (in_ctrl & ~KILL_MASK);
            wn_next    = in_wn;
        end
        if (kill_en && CLR_DATA) begin
            wn_next = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DATA; gi++) begin : g_operand
            assign data_next[gi*DATA_W +: DATA_W] =
                load_en               ? in_data[gi*DATA_W +: DATA_W] :
                (kill_en && CLR_DATA) ? {DATA_W{1'b0}} :
                                        data_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            wn_reg    <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            ctrl_reg  <= ctrl_next;
            wn_reg    <= wn_next;
            data_reg  <= data_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_ctrl  = ctrl_reg;
    assign out_wn    = wn_reg;
    assign out_data  = data_reg;

    // A flush only counts when it actually discards a live instruction.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (hold_en),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (!flush && !stall && bubble),
        .count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (flush && valid_reg),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations driven in parallel, checked against a behavioural model.
module tb_pipe_stage_reg;

    localparam logic [11:0] KILL = 12'h805;   // wreg (bit 0), wmem (bit 2), store-hazard (bit 11)

    logic        clk;
    logic        clr, stall, flush, bubble, in_valid;
    logic [11:0] in_ctrl;
    logic [4:0]  in_wn;
    logic [95:0] in_data;

    logic        a_valid, b_valid;
    logic [11:0] a_ctrl, b_ctrl;
    logic [4:0]  a_wn, b_wn;
    logic [95:0] a_data, b_data;
    logic [15:0] a_scnt, a_bcnt, a_fcnt;
    logic [2:0]  b_scnt, b_bcnt, b_fcnt;

    pipe_stage_reg dut_a (
        .clk(clk), .clr(clr), .stall(stall), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_wn(in_wn), .in_data(in_data),
        .out_valid(a_valid), .out_ctrl(a_ctrl), .out_wn(a_wn), .out_data(a_data),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt), .flush_cnt(a_fcnt)
    );

    pipe_stage_reg #(.CLR_DATA_ON_KILL(1), .CNT_W(3)) dut_b (
        .clk(clk), .clr(clr), .stall(stall), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_wn(in_wn), .in_data(in_data),
        .out_valid(b_valid), .out_ctrl(b_ctrl), .out_wn(b_wn), .out_data(b_data),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt), .flush_cnt(b_fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state, index 0 = default config, 1 = cleared-data / 3-bit-counter config.
    logic        m_valid [2];
    logic [11:0] m_ctrl  [2];
    logic [4:0]  m_wn    [2];
    logic [95:0] m_data  [2];
    int          m_scnt  [2];
    int          m_bcnt  [2];
    int          m_fcnt  [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int  maxv    = (d == 0) ? 65535 : 7;
            bit  clrdata = (d == 1);
            if (clr) begin
                m_valid[d] = 1'b0; m_ctrl[d] = '0; m_wn[d] = '0; m_data[d] = '0;
                m_scnt[d] = 0; m_bcnt[d] = 0; m_fcnt[d] = 0;
            end else if (flush) begin
                if (m_valid[d]) m_fcnt[d] = sat_inc(m_fcnt[d], maxv);
                m_valid[d] = 1'b0;
                m_ctrl[d]  = m_ctrl[d] & ~KILL;
                if (clrdata) begin m_wn[d] = '0; m_data[d] = '0; end
            end else if (stall) begin
                m_scnt[d] = sat_inc(m_scnt[d], maxv);
            end else if (bubble) begin
                m_valid[d] = 1'b0;
                m_ctrl[d]  = in_ctrl & ~KILL;
                if (clrdata) begin m_wn[d] = '0; m_data[d] = '0; end
                m_bcnt[d] = sat_inc(m_bcnt[d], maxv);
            end else begin
                m_valid[d] = in_valid;
                m_ctrl[d]  = in_valid ? in_ctrl : (in_ctrl & ~KILL);
                m_wn[d]    = in_wn;
                m_data[d]  = in_data;
            end
        end
    endtask

    task automatic compare_all();
        check("a_valid", 96'(a_valid), 96'(m_valid[0]));
        check("a_ctrl",  96'(a_ctrl),  96'(m_ctrl[0]));
        check("a_wn",    96'(a_wn),    96'(m_wn[0]));
        check("a_data",  a_data,       m_data[0]);
        check("a_scnt",  96'(a_scnt),  96'(m_scnt[0]));
        check("a_bcnt",  96'(a_bcnt),  96'(m_bcnt[0]));
        check("a_fcnt",  96'(a_fcnt),  96'(m_fcnt[0]));
        check("b_valid", 96'(b_valid), 96'(m_valid[1]));
        check("b_ctrl",  96'(b_ctrl),  96'(m_ctrl[1]));
        check("b_wn",    96'(b_wn),    96'(m_wn[1]));
        check("b_data",  b_data,       m_data[1]);
        check("b_scnt",  96'(b_scnt),  96'(m_scnt[1]));
        check("b_bcnt",  96'(b_bcnt),  96'(m_bcnt[1]));
        check("b_fcnt",  96'(b_fcnt),  96'(m_fcnt[1]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        clr = 0; stall = 0; flush = 0; bubble = 0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_ctrl[d] = 0; m_wn[d] = 0; m_data[d] = 0;
            m_scnt[d] = 0; m_bcnt[d] = 0; m_fcnt[d] = 0;
        end
        idle();
        clr = 1; in_valid = 1; in_ctrl = 12'hFFF; in_wn = 5'd31; in_data = '1;

        // Reset held for two cycles with busy inputs.
        tick(); tick();
        check("rst_valid", 96'(a_valid), 96'd0);
        check("rst_data",  a_data,       96'd0);
        check("rst_scnt",  96'(a_scnt),  96'd0);

        // First load after release.
        clr = 0; in_wn = 5'd5; in_data = 96'h11; in_ctrl = 12'h123;
        tick();
        check("load_wn",    96'(a_wn),    96'd5);
        check("load_qa",    96'(a_data[31:0]), 96'h11);
        check("load_valid", 96'(a_valid), 96'd1);

        // Stall holds for three cycles while the input changes.
        in_data = 96'hA5A5A5A5;
        tick();
        stall = 1; in_data = '0; in_wn = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 96'(a_data[31:0]), 96'hA5A5A5A5);
        end
        check("stall_cnt3", 96'(a_scnt), 96'd3);
        stall = 0;

        // Bubble with the default kill mask.
        in_ctrl = 12'hFFF; in_valid = 1; bubble = 1;
        tick();
        check("bub_valid", 96'(a_valid), 96'd0);
        check("bub_ctrl",  96'(a_ctrl),  96'h7FA);
        check("bub_cnt",   96'(a_bcnt),  96'd1);
        bubble = 0;

        // Flush beats stall and bubble on a valid slot.
        in_data = 96'h1234_5678_9ABC_DEF0_CAFE_F00D; in_wn = 5'd17;
        tick();
        stall = 1; flush = 1; bubble = 1;
        tick();
        check("fl_valid", 96'(a_valid), 96'd0);
        check("fl_fcnt",  96'(a_fcnt),  96'd1);
        check("fl_scnt",  96'(a_scnt),  96'd3);
        check("fl_bcnt",  96'(a_bcnt),  96'd1);
        check("fl_bdata", b_data,       96'd0);
        check("fl_adata", a_data,       96'h1234_5678_9ABC_DEF0_CAFE_F00D);
        idle();

        // Stall and bubble together: stall wins, bubble lands next cycle.
        tick();
        stall = 1; bubble = 1;
        tick();
        check("sb_bcnt",  96'(a_bcnt),  96'd1);
        check("sb_valid", 96'(a_valid), 96'd1);
        stall = 0;
        tick();
        check("sb_bcnt2", 96'(a_bcnt),  96'd2);
        check("sb_nop",   96'(a_valid), 96'd0);
        idle();

        // Saturation of the 3-bit counter, then reset.
        clr = 1;
        tick();
        clr = 0; stall = 1;
        for (int i = 0; i < 10; i++) tick();
        check("sat_b", 96'(b_scnt), 96'd7);
        check("sat_a", 96'(a_scnt), 96'd10);
        stall = 0; clr = 1;
        tick();
        check("sat_clr", 96'(b_scnt), 96'd0);
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            clr      = ($urandom_range(99) < 2);
            flush    = ($urandom_range(99) < 10);
            stall    = ($urandom_range(99) < 20);
            bubble   = ($urandom_range(99) < 15);
            in_valid = $urandom_range(1);
            in_ctrl  = 12'($urandom);
            in_wn    = 5'($urandom);
            in_data  = {$urandom, $urandom, $urandom};
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
